// File: rtl/dpram_be_fwd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dpram_be_fwd                                                  |
// | Description: True dual-port RAM with per-byte write enables, read-valid    |
// |              tracking, optional output register, same-port and            |
// |              cross-port write forwarding, and write-collision flag.       |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module dpram_be_fwd #(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int OUT_REG   = 0,
  parameter int WMODE_A   = 0,
  parameter int WMODE_B   = 0,
  parameter int CROSS_FWD = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_a,
  input  logic [AW-1:0]   addr_a,
  input  logic [DW/8-1:0] we_a,
  input  logic [DW-1:0]   di_a,
  output logic [DW-1:0]   do_a,
  output logic            vld_a,
  input  logic            en_b,
  input  logic [AW-1:0]   addr_b,
  input  logic [DW/8-1:0] we_b,
  input  logic [DW-1:0]   di_b,
  output logic [DW-1:0]   do_b,
  output logic            vld_b,
  output logic            coll
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Lane-by-lane merge of the pre-write word with both ports' write data.
  // Port A lanes take priority, matching the order the array is written.
  function automatic logic [DW-1:0] merge_word(
    input logic [DW-1:0] old_w,
    input logic [NB-1:0] msk_a,
    input logic [DW-1:0] dat_a,
    input logic [NB-1:0] msk_b,
    input logic [DW-1:0] dat_b
  );
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (msk_a[i])      res[8*i +: 8] = dat_a[8*i +: 8];
      else if (msk_b[i]) res[8*i +: 8] = dat_b[8*i +: 8];
    end
    return res;
  endfunction

  // Write-lane masks as seen from each port's read address
  logic          w_same_addr;
  logic [NB-1:0] w_wa_self;   // A lanes written into A's read word
  logic [NB-1:0] w_wb_on_a;   // B lanes written into A's read word
  logic [NB-1:0] w_wb_self;   // B lanes written into B's read word
  logic [NB-1:0] w_wa_on_b;   // A lanes written into B's read word
  logic          w_fwd_a;
  logic          w_fwd_b;

  // Decide per port whether the read returns the merged (final) word.
  // A port's own write follows its WMODE; otherwise the other port's write
  // into the same word follows CROSS_FWD.
  always_comb begin
    w_same_addr = (addr_a == addr_b);
    w_wa_self   = en_a ? we_a : '0;
    w_wb_self   = en_b ? we_b : '0;
    w_wb_on_a   = (en_b && w_same_addr) ? we_b : '0;
    w_wa_on_b   = (en_a && w_same_addr) ? we_a : '0;
    w_fwd_a     = 1'b0;
    w_fwd_b     = 1'b0;
    if (|w_wa_self)      w_fwd_a = (WMODE_A != 0);
    else if (|w_wb_on_a) w_fwd_a = (CROSS_FWD != 0);
    if (|w_wb_self)      w_fwd_b = (WMODE_B != 0);
    else if (|w_wa_on_b) w_fwd_b = (CROSS_FWD != 0);
  end

  // Array write: B first, then A, so A owns lanes both ports enable
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NB; i++) begin
        if (en_b && we_b[i]) mem[addr_b][8*i +: 8] <= di_b[8*i +: 8];
      end
      for (int i = 0; i < NB; i++) begin
        if (en_a && we_a[i]) mem[addr_a][8*i +: 8] <= di_a[8*i +: 8];
      end
    end
  end

  // Read stage: raw pre-write word plus registered forwarding masks/data.
  // Data registers load only on an access so the output holds otherwise.
  logic          va_q, vb_q;
  logic [DW-1:0] old_a_q, old_b_q;
  logic [NB-1:0] ma_a_q, mb_a_q, ma_b_q, mb_b_q;
  logic [DW-1:0] da_a_q, db_a_q, da_b_q, db_b_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      va_q    <= 1'b0;
      vb_q    <= 1'b0;
      old_a_q <= '0;
      old_b_q <= '0;
      ma_a_q  <= '0;
      mb_a_q  <= '0;
      ma_b_q  <= '0;
      mb_b_q  <= '0;
      da_a_q  <= '0;
      db_a_q  <= '0;
      da_b_q  <= '0;
      db_b_q  <= '0;
    end else begin
      va_q <= en_a;
      vb_q <= en_b;
      if (en_a) begin
        old_a_q <= mem[addr_a];
        ma_a_q  <= w_fwd_a ? w_wa_self : '0;
        mb_a_q  <= w_fwd_a ? w_wb_on_a : '0;
        da_a_q  <= di_a;
        db_a_q  <= di_b;
      end
      if (en_b) begin
        old_b_q <= mem[addr_b];
        ma_b_q  <= w_fwd_b ? w_wa_on_b : '0;
        mb_b_q  <= w_fwd_b ? w_wb_self : '0;
        da_b_q  <= di_a;
        db_b_q  <= di_b;
      end
    end
  end

  logic [DW-1:0] w_rd_a, w_rd_b;

  // Apply forwarded lanes to the raw read word
  always_comb begin
    w_rd_a = merge_word(old_a_q, ma_a_q, da_a_q, mb_a_q, db_a_q);
    w_rd_b = merge_word(old_b_q, ma_b_q, da_b_q, mb_b_q, db_b_q);
  end

  // Collision: same word written by both ports with overlapping lanes
  logic coll_q;
  always_ff @(posedge clk) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= en_a && en_b && w_same_addr && (|(we_a & we_b));
  end
  assign coll = coll_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] do_a_q, do_b_q;
    logic          vld_a_q, vld_b_q;

    // Second pipeline stage; loads only when the first stage completed a read
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        do_a_q  <= '0;
        do_b_q  <= '0;
        vld_a_q <= 1'b0;
        vld_b_q <= 1'b0;
      end else begin
        vld_a_q <= va_q;
        vld_b_q <= vb_q;
        if (va_q) do_a_q <= w_rd_a;
        if (vb_q) do_b_q <= w_rd_b;
      end
    end

    assign do_a  = do_a_q;
    assign do_b  = do_b_q;
    assign vld_a = vld_a_q;
    assign vld_b = vld_b_q;
  end else begin : g_out_direct
    assign do_a  = w_rd_a;
    assign do_b  = w_rd_b;
    assign vld_a = va_q;
    assign vld_b = vb_q;
  end

endmodule
`default_nettype wire
